// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: drain FSM states and
// width helpers used by the result drain and its capture buffers.
package systolic_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    // A product of two operands needs twice the operand width.
    localparam int RESULT_WIDTH_FACTOR = 2;

    function automatic int result_elem_width(input int data_width);
        return RESULT_WIDTH_FACTOR * data_width;
    endfunction

    // Row index width, never narrower than one bit so a single-row array still
    // has a usable index port.
    function automatic int row_idx_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_buf.sv
// Result capture register: stores a whole result matrix on load and presents
// one selected row. Holds no validity of its own; the drain FSM tracks that.
module systolic_result_buf
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
) (
    input  logic                                               clk,
    input  logic                                               load,
    input  logic [result_elem_width(DATA_WIDTH)*ROWS*COLS-1:0] load_data,
    input  logic [row_idx_width(ROWS)-1:0]                     row_sel,
    output logic [result_elem_width(DATA_WIDTH)*COLS-1:0]      row_data
);

    localparam int ROW_W = result_elem_width(DATA_WIDTH) * COLS;
    localparam int IDX_W = row_idx_width(ROWS);

    logic [ROW_W*ROWS-1:0] data_q;

    // Capture the full matrix; contents are only meaningful while the FSM says so.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= load_data;
        end
    end

    // Select the requested row; row 0 sits in the least significant slice.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel == IDX_W'(r)) begin
                row_data = data_q[r*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Systolic array result drain: captures the flat result bus on the array's
// valid pulse and streams it out one row per valid/ready beat.
// Optional feature macro: SYSTOLIC_DRAIN_DBUF_EN adds a pending buffer so a
// new result can be accepted while the previous one is still draining.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               in_valid,
    input  logic [result_elem_width(DATA_WIDTH)*ROWS*COLS-1:0] in_C,
    output logic                                               in_ready,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic [result_elem_width(DATA_WIDTH)*COLS-1:0]      out_data,
    output logic [row_idx_width(ROWS)-1:0]                     out_row,
    output logic                                               out_last,
    output logic                                               busy,
    output logic                                               overflow,
    input  logic                                               clr_ovf
);

    localparam int ROW_IDX_W = row_idx_width(ROWS);
    localparam int ROW_W     = result_elem_width(DATA_WIDTH) * COLS;
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

    drain_state_t         state, state_n;
    logic [ROW_IDX_W-1:0] row, row_n;
    logic                 main_load;
    logic [ROW_W-1:0]     main_row;

`ifdef SYSTOLIC_DRAIN_DBUF_EN
    // Two buffers in ping-pong: cur_sel names the one being drained, the other
    // is the pending slot. Promoting pending to main is just a flip of cur_sel.
    logic             cur_sel, cur_sel_n;
    logic             pend_full, pend_full_n;
    logic             pend_load;
    logic             load_a, load_b;
    logic [ROW_W-1:0] row_a, row_b;

    assign load_a = (main_load && !cur_sel) || (pend_load && cur_sel);
    assign load_b = (main_load && cur_sel)  || (pend_load && !cur_sel);

    systolic_result_buf #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS)) u_buf_a (
        .clk       (clk),
        .load      (load_a),
        .load_data (in_C),
        .row_sel   (row),
        .row_data  (row_a)
    );

    systolic_result_buf #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS)) u_buf_b (
        .clk       (clk),
        .load      (load_b),
        .load_data (in_C),
        .row_sel   (row),
        .row_data  (row_b)
    );

    assign main_row = cur_sel ? row_b : row_a;
    assign in_ready = (state == IDLE) || !pend_full;
    assign busy     = (state == DRAIN) || pend_full;
`else
    systolic_result_buf #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .COLS(COLS)) u_buf_main (
        .clk       (clk),
        .load      (main_load),
        .load_data (in_C),
        .row_sel   (row),
        .row_data  (main_row)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state == DRAIN);
`endif

    assign out_row  = row;
    assign out_last = out_valid && (row == LAST_ROW);
    assign out_data = out_valid ? main_row : '0;

    // State, row counter and buffer bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
`ifdef SYSTOLIC_DRAIN_DBUF_EN
            cur_sel   <= 1'b0;
            pend_full <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            row       <= row_n;
`ifdef SYSTOLIC_DRAIN_DBUF_EN
            cur_sel   <= cur_sel_n;
            pend_full <= pend_full_n;
`endif
        end
    end

    // Next-state logic: capture in IDLE, walk the rows in DRAIN, and on the
    // final beat either chain into the next result or fall back to IDLE.
    always_comb begin
        state_n   = state;
        row_n     = row;
        out_valid = 1'b0;
        main_load = 1'b0;
`ifdef SYSTOLIC_DRAIN_DBUF_EN
        cur_sel_n   = cur_sel;
        pend_full_n = pend_full;
        pend_load   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    main_load = 1'b1;
                    row_n     = '0;
                    state_n   = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row == LAST_ROW) begin
                        row_n = '0;
`ifdef SYSTOLIC_DRAIN_DBUF_EN
                        if (pend_full) begin
                            cur_sel_n   = !cur_sel;
                            pend_full_n = 1'b0;
                        end else if (in_valid) begin
                            main_load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
`else
                        state_n = IDLE;
`endif
                    end else begin
                        row_n = row + ROW_IDX_W'(1);
                    end
                end
`ifdef SYSTOLIC_DRAIN_DBUF_EN
                if (in_valid && !pend_full && !(out_ready && (row == LAST_ROW))) begin
                    pend_load   = 1'b1;
                    pend_full_n = 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Sticky overflow: a dropped result is recorded and wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain. Expected beats come from a
// plain matrix model: row r of a result is element (r,c) for c = 0..COLS-1.
// Scenarios for SYSTOLIC_DRAIN_DBUF_EN are selected by the same macro.
module tb_systolic_result_drain;

    localparam int DW      = 8;
    localparam int R       = 8;
    localparam int C       = 8;
    localparam int EW      = 2 * DW;
    localparam int ROW_W   = EW * C;
    localparam int TOTAL_W = ROW_W * R;
    localparam int RW      = 3;
`ifdef SYSTOLIC_DRAIN_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [TOTAL_W-1:0] in_C;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [ROW_W-1:0]   out_data;
    logic [RW-1:0]      out_row;
    logic               out_last;
    logic               busy;
    logic               overflow;
    logic               clr_ovf;

    int errors = 0;
    int checks = 0;

    logic signed [EW-1:0] mat [R][C];
    logic [ROW_W-1:0]     exp_data_q [$];
    int                   exp_idx_q  [$];

    always #5 clk = ~clk;

    systolic_result_drain #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_C      (in_C),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    function automatic logic [TOTAL_W-1:0] pack_mat();
        logic [TOTAL_W-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                v[(r*C+c)*EW +: EW] = mat[r][c];
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < C; c++)
            v[c*EW +: EW] = mat[r][c];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mat[r][c] = EW'($urandom);
    endtask

    task automatic queue_result();
        for (int r = 0; r < R; r++) begin
            exp_data_q.push_back(exp_row(r));
            exp_idx_q.push_back(r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_C = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (out_row !== '0) begin errors++; $display("[TB] FAIL reset_out_row: got %0d expected 0", out_row); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_throughput();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mat[r][c] = EW'(r*8 + c);
        out_ready = 1'b1;
        in_C = pack_mat(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int r = 0; r < R; r++) begin
            checks++;
            if ({out_valid, out_row, out_last, out_data, in_ready} !== {1'b1, RW'(r), (r == R-1), exp_row(r), DBUF}) begin
                errors++;
                $display("[TB] FAIL full_beat%0d: got v=%b row=%0d last=%b rdy=%b data=%h expected v=1 row=%0d last=%b rdy=%b data=%h",
                         r, out_valid, out_row, out_last, in_ready, out_data, r, (r == R-1), DBUF, exp_row(r));
            end
            step();
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_in_ready_after: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_out_valid_after: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        for (int mode = 0; mode < 2; mode++) begin
            int idx;
            int cyc;
            fill_random();
            out_ready = 1'b0;
            in_C = pack_mat(); in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            idx = 0;
            cyc = 0;
            while (idx < R && cyc < 100) begin
                out_ready = (mode == 0) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
                checks++;
                if ({out_valid, out_row, out_last, out_data} !== {1'b1, RW'(idx), (idx == R-1), exp_row(idx)}) begin
                    errors++;
                    $display("[TB] FAIL bp_mode%0d_cyc%0d: got v=%b row=%0d last=%b data=%h expected v=1 row=%0d last=%b data=%h",
                             mode, cyc, out_valid, out_row, out_last, out_data, idx, (idx == R-1), exp_row(idx));
                end
                if (out_ready) idx++;
                step();
                cyc++;
            end
            checks++; if (idx != R) begin errors++; $display("[TB] FAIL bp_mode%0d_timeout: got %0d beats expected %0d", mode, idx, R); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_mode%0d_done: got out_valid=%b expected 0", mode, out_valid); end
        end
    endtask

    task automatic test_negative();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                mat[r][c] = EW'(-(r*8 + c + 1));
        out_ready = 1'b1;
        in_C = pack_mat(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (out_data[EW-1:0] !== 16'hFFFF) begin errors++; $display("[TB] FAIL neg_r0c0: got %h expected ffff", out_data[EW-1:0]); end
        for (int r = 0; r < R; r++) begin
            checks++;
            if ({out_valid, out_row, out_data} !== {1'b1, RW'(r), exp_row(r)}) begin
                errors++;
                $display("[TB] FAIL neg_beat%0d: got v=%b row=%0d data=%h expected v=1 row=%0d data=%h",
                         r, out_valid, out_row, out_data, r, exp_row(r));
            end
            step();
        end
    endtask

`ifndef SYSTOLIC_DRAIN_DBUF_EN
    task automatic test_overflow();
        int cyc;
        fill_random();
        out_ready = 1'b1;
        in_C = pack_mat(); in_valid = 1'b1;
        step();
        for (int r = 0; r < R; r++) begin
            if (r == 3) begin
                in_C = ~pack_mat(); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            checks++;
            if ({out_valid, out_row, out_data, overflow} !== {1'b1, RW'(r), exp_row(r), (r >= 4)}) begin
                errors++;
                $display("[TB] FAIL ovf_beat%0d: got v=%b row=%0d ovf=%b data=%h expected v=1 row=%0d ovf=%b data=%h",
                         r, out_valid, out_row, overflow, out_data, r, (r >= 4), exp_row(r));
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drop_not_drained: got out_valid=%b expected 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", overflow); end
        fill_random();
        in_C = pack_mat(); in_valid = 1'b1;
        step();
        in_valid = 1'b1; clr_ovf = 1'b1;
        step();
        in_valid = 1'b0; clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set_beats_clear: got %b expected 1", overflow); end
        cyc = 0;
        while (out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drain_timeout: got out_valid=%b expected 0", out_valid); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_final_clear: got %b expected 0", overflow); end
    endtask
`else
    task automatic test_back_to_back();
        int k;
        exp_data_q.delete();
        exp_idx_q.delete();
        out_ready = 1'b1;
        fill_random();
        queue_result();
        in_C = pack_mat(); in_valid = 1'b1;
        step();
        for (k = 0; k < 3*R; k++) begin
            logic [ROW_W-1:0] ed;
            int ei;
            if (k == 2 || k == 2*R-1) begin
                fill_random();
                queue_result();
                in_C = pack_mat(); in_valid = 1'b1;
            end else if (k == 4) begin
                fill_random();
                in_C = pack_mat(); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            ed = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : '0;
            ei = (exp_idx_q.size() > 0) ? exp_idx_q.pop_front() : 0;
            checks++;
            if ({out_valid, out_row, out_last, out_data, overflow} !== {1'b1, RW'(ei), (ei == R-1), ed, (k >= 5)}) begin
                errors++;
                $display("[TB] FAIL b2b_cyc%0d: got v=%b row=%0d last=%b ovf=%b data=%h expected v=1 row=%0d last=%b ovf=%b data=%h",
                         k, out_valid, out_row, out_last, overflow, out_data, ei, (ei == R-1), (k >= 5), ed);
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done_in_ready: got %b expected 1", in_ready); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_drain();
        fill_random();
        out_ready = 1'b1;
        in_C = pack_mat(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step(); step();
        checks++; if (out_row !== RW'(4)) begin errors++; $display("[TB] FAIL rstmid_at_row4: got %0d expected 4", out_row); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        fill_random();
        in_C = pack_mat(); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int r = 0; r < R; r++) begin
            checks++;
            if ({out_valid, out_row, out_last, out_data} !== {1'b1, RW'(r), (r == R-1), exp_row(r)}) begin
                errors++;
                $display("[TB] FAIL rstmid_beat%0d: got v=%b row=%0d last=%b data=%h expected v=1 row=%0d last=%b data=%h",
                         r, out_valid, out_row, out_last, out_data, r, (r == R-1), exp_row(r));
            end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done: got out_valid=%b expected 0", out_valid); end
    endtask

    initial begin
        $display("[TB] starting systolic_result_drain bench (double buffer=%0d)", DBUF);
        test_reset();
        test_full_throughput();
        test_backpressure();
        test_negative();
`ifndef SYSTOLIC_DRAIN_DBUF_EN
        test_overflow();
`else
        test_back_to_back();
`endif
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Output-side reader for the systolic array. Captures the flat result bus `C` on the array's one-cycle `valid` pulse and streams it out one row per beat over a valid/ready interface, with row index and last-row marker. Sits between the PE array result port and any downstream consumer (DMA, FIFO, host bridge), mirroring the input controller on the operand side.

## Interface
- `DATA_WIDTH`, 8, operand width; each result element is `2*DATA_WIDTH` bits, signed.
- `ROWS`, 8, array rows; number of beats per result.
- `COLS`, 8, array columns; elements per beat.
- `clk`  input  1  single clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  one-cycle result pulse from the PE array.
- `in_C`  input  `2*DATA_WIDTH*ROWS*COLS`  result matrix; element (r,c) at bits `[(r*COLS+c)*2*DATA_WIDTH +: 2*DATA_WIDTH]`.
- `in_ready`  output  1  capture storage free this cycle.
- `out_valid`  output  1  row beat available.
- `out_ready`  input  1  consumer accepts beat.
- `out_data`  output  `2*DATA_WIDTH*COLS`  row r = `in_C[r*COLS*2*DATA_WIDTH +: COLS*2*DATA_WIDTH]`, column 0 in LSBs.
- `out_row`  output  `$clog2(ROWS)` (min 1)  row index of current beat.
- `out_last`  output  1  high with the beat of row `ROWS-1`.
- `busy`  output  1  high whenever any result is held.
- `overflow`  output  1  sticky; an `in_valid` arrived while `in_ready` low.
- `clr_ovf`  input  1  clears `overflow`.

## Operation
- FSM states: `IDLE`, `DRAIN`.
- `IDLE`: `in_ready`=1. `in_valid` -> copy `in_C` into main buffer, row counter=0, go `DRAIN`.
- `DRAIN`: `out_valid`=1, `out_data` = main buffer row `row`. Handshake = `out_valid && out_ready`; advances row by 1.
- Handshake on row `ROWS-1`: if a pending result exists (see Configuration) move it to main, row=0, stay `DRAIN`; else go `IDLE`.
- `out_data`, `out_row`, `out_last` stable while `out_valid && !out_ready`; `out_valid` never drops before handshake.
- No arithmetic; data passed bit-exact, sign untouched.
- `overflow` set on `in_valid && !in_ready`; the dropped result is discarded, current drain unaffected. Set wins over simultaneous `clr_ovf`.
- `busy` = (state==`DRAIN`) or pending held.
- Reset (any state, mid-drain included): state `IDLE`, row 0, buffers invalidated, in-flight beats lost.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_row`=0, `out_last`=0, `busy`=0, `overflow`=0, `in_ready`=1.
- Latency: `in_valid` at cycle N -> `out_valid`=1 with row 0 at N+1.
- Full-throughput drain: `ROWS` beats in `ROWS` cycles with `out_ready` held high.
- Without double buffer: `in_ready`=0 for entire `DRAIN`, including the final-handshake cycle; next capture earliest the cycle after returning to `IDLE`.
- `in_ready` is a function of registered state only (no combinational path from `out_ready`).

## Configuration
- `SYSTOLIC_DRAIN_DBUF_EN` defined: one pending buffer added. In `DRAIN`, `in_ready` = !pending_full; capture goes to pending. If `in_valid` coincides with final handshake and pending empty, capture goes straight into main, row=0, no bubble. Back-to-back results drain with zero idle cycles.
- Not defined: single buffer only; behaviour as in Timing; pending logic absent.

## Structure
- Shared package `systolic_pkg`: state enum (`IDLE`, `DRAIN`), row-index width helper (`$clog2` with minimum 1), result-element width constant `2*DATA_WIDTH`.
- One sub-module: `systolic_result_buf` — capture register with load enable and row-select mux; instantiated once (twice with `SYSTOLIC_DRAIN_DBUF_EN`).

## Test plan
- Defaults, element (r,c)=r*8+c, `out_ready`=1: pulse `in_valid` -> 8 beats on consecutive cycles, beat r has column c = r*8+c, `out_last` only on row 7, `in_ready` returns 1 after.
- Backpressure: `out_ready` toggled 1,0,0,1,... -> rows 0..7 in order, `out_data`/`out_row` held constant across stalled cycles, no beat skipped or duplicated.
- Negative values: element (r,c)=-(r*8+c+1) -> output bit-exact, e.g. row 0 col 0 = 16'hFFFF.
- Overflow: second `in_valid` at row 3 (macro off) -> `overflow`=1, first result drains intact; `clr_ovf` -> 0; `clr_ovf` with coincident drop -> stays 1.
- `SYSTOLIC_DRAIN_DBUF_EN`: two results 3 cycles apart -> 16 contiguous beats, second result row 0 the cycle after first `out_last`; third pulse while pending full -> `overflow`=1.
- `rst` asserted at row 4 -> next cycle `out_valid`=0, `busy`=0, `in_ready`=1; new `in_valid` restarts at row 0.
